cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Multi-cycle successor to the combinational LEGv8 control decoder.
- Decodes the 11-bit opcode field (inst[31:21]) once per instruction and sequences the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memory; memory latency is variable, with a parametrised timeout.
- Adds sticky HALT/error handling and corrected branch RegWrite behaviour.

Parameters:
- MEM_TIMEOUT, 16: max MEM-state cycles without mem_ack before bus error. 0 disables the timeout.
- ILLEGAL_TRAP, 1: 1 means an illegal opcode enters ERROR (sticky). 0 means it is skipped as a NOP with a 1-cycle illegal_op pulse.
- ALUOP_W, 2: width of alu_op.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst31_21  in  11  opcode field. Valid while inst_valid=1 in FETCH.
- inst_valid  in  1  instruction memory has a word available.
- inst_ready  out  1  FSM accepts an instruction (FETCH only).
- mem_ack  in  1  data memory completed the current access.
- ir_write  out  1  latch instruction register (FETCH & inst_valid).
- pc_write  out  1  update PC. 1-cycle pulse on the last cycle of each instruction.
- reg2loc  out  1  register-read select.
- alu_src  out  2  ALU operand-B select.
- alu_op  out  ALUOP_W  ALU operation class.
- branch  out  1  unconditional branch (EXEC only).
- branch_zero  out  1  CBZ (EXEC only).
- branch_nonzero  out  1  CBNZ (EXEC only).
- mem_read  out  1  data read request (MEM, LDUR).
- mem_write  out  1  data write request (MEM, STUR).
- mem_to_reg  out  1  writeback source is memory.
- reg_write  out  1  register-file write (WB only, 1 cycle).
- halted  out  1  sticky, HALT executed.
- illegal_op  out  1  illegal opcode (sticky if ILLEGAL_TRAP=1, else 1-cycle pulse).
- bus_err  out  1  sticky, MEM timeout.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5, ERROR=6.

Behaviour:
- Reset (async, rst_n=0): state=FETCH. Decode register cleared to all-zero bundle. Sticky flags cleared. Timeout counter cleared.
- After reset, all outputs are 0 except inst_ready=1.
- Decode priority, first match wins:
  - LDUR 11111000010
  - STUR 11111000000
  - ADD 10001011000
  - ADDI 1001000100x
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
  - CBZ 10110100xxx
  - CBNZ 10110101xxx
  - B 000101xxxxx
  - HALT 11111111111
  - Anything else is illegal.
- Decode bundle values (reg2loc / alu_src / alu_op / mem_to_reg):
  - LDUR: 0 / 01 / 00 / 1
  - STUR: 1 / 01 / 00 / 0
  - ADD, SUB, AND, ORR: 0 / 00 / 10 / 0
  - ADDI: 0 / 10 / 10 / 0
  - CBZ, CBNZ: 1 / 00 / 01 / 0
  - B, HALT: all 0
  - Branches never write registers.
- Opcode is sampled into an IR copy on FETCH & inst_valid. The decode bundle is registered at the end of DECODE and held through WB.
- reg2loc, alu_src, alu_op and mem_to_reg are driven from the bundle in EXEC/MEM/WB. They are 0 elsewhere.
- Transitions:
  - FETCH: stays while inst_valid=0. Goes to DECODE when inst_valid=1.
  - DECODE:
    - HALT → HALTED.
    - Illegal with ILLEGAL_TRAP=1 → ERROR.
    - Illegal with ILLEGAL_TRAP=0 → FETCH, with pc_write=1 and illegal_op=1 for that cycle.
    - Otherwise → EXEC.
  - EXEC: B/CBZ/CBNZ → FETCH with pc_write. LDUR/STUR → MEM. ALU ops → WB.
  - MEM:
    - mem_read/mem_write held until mem_ack. The counter increments each cycle without ack.
    - On ack: LDUR → WB; STUR → FETCH with pc_write.
    - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without ack: → ERROR and set bus_err. That cycle still drives the request.
  - WB: reg_write=1, pc_write=1 → FETCH.
  - HALTED and ERROR: terminal, exited only by reset. All strobes are 0 and inst_ready=0.
- Latency, from inst_valid accepted:
  - Branch: 3 cycles.
  - ALU: 4 cycles.
  - STUR: 3+N cycles; LDUR: 4+N cycles, where N≥1 is the number of MEM cycles.
- mem_ack outside MEM is ignored. inst_valid outside FETCH is ignored.
- The timeout counter clears on entry to MEM and has width clog2(MEM_TIMEOUT+1).
- Reset asserted mid-instruction (e.g. in MEM) drops all requests immediately (async) and returns to FETCH.

Test Plan:
- ADD 10001011000, inst_valid held 1 → states 0,1,2,4,0. reg_write=1 and pc_write=1 only in state 4. alu_op=10, alu_src=00.
- LDUR with mem_ack arriving in the 3rd MEM cycle → mem_read=1 for 3 cycles. Then WB with mem_to_reg=1, reg_write=1. Total 7 cycles.
- CBZ 10110100101 → branch_zero=1 only in EXEC. reg_write never 1. pc_write pulse in EXEC. ADDI 10010001001 → alu_src=10.
- STUR with mem_ack never asserted, MEM_TIMEOUT=4 → after 4 MEM cycles state=6, bus_err=1 sticky. Further inst_valid is ignored.
- Opcode 00000000000: with ILLEGAL_TRAP=1 → state=6, illegal_op=1 held. With ILLEGAL_TRAP=0 → 1-cycle illegal_op and pc_write pulse, then back to FETCH.
- HALT 11111111111 → state=5, halted=1. Asserting rst_n=0 mid-MEM of a later run clears mem_read the same cycle; state=0 after release.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, a bounded MEM wait and sticky HALTED/ERROR terminal states.
module cpu_control_fsm #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ILLEGAL_TRAP = 1,
    parameter int ALUOP_W      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [10:0]        inst31_21,
    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic               mem_ack,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg2loc,
    output logic [1:0]         alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               branch,
    output logic               branch_zero,
    output logic               branch_nonzero,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               halted,
    output logic               illegal_op,
    output logic               bus_err,
    output logic [2:0]         state
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_ILL  = 3'd0,
        K_LDUR = 3'd1,
        K_STUR = 3'd2,
        K_ALU  = 3'd3,
        K_BR   = 3'd4,
        K_CBZ  = 3'd5,
        K_CBNZ = 3'd6,
        K_HALT = 3'd7
    } kind_t;

    typedef struct packed {
        kind_t              kind;
        logic               reg2loc;
        logic [1:0]         alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_to_reg;
    } bundle_t;

    typedef struct packed {
        logic               inst_ready;
        logic               pc_write;
        logic               reg2loc;
        logic [1:0]         alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               branch;
        logic               branch_zero;
        logic               branch_nonzero;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
    } outs_t;

    function automatic bundle_t decode_op(input logic [10:0] op);
        bundle_t d;
        d = '0;
        casez (op)
            11'b11111000010: begin d.kind = K_LDUR; d.alu_src = 2'b01; d.mem_to_reg = 1'b1; end
            11'b11111000000: begin d.kind = K_STUR; d.reg2loc = 1'b1; d.alu_src = 2'b01; end
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: begin d.kind = K_ALU; d.alu_op = ALUOP_W'(2'b10); end
            11'b1001000100?: begin
                d.kind    = K_ALU;
                d.alu_src = 2'b10;
                d.alu_op  = ALUOP_W'(2'b10);
            end
            11'b10110100???: begin d.kind = K_CBZ; d.reg2loc = 1'b1; d.alu_op = ALUOP_W'(2'b01); end
            11'b10110101???: begin d.kind = K_CBNZ; d.reg2loc = 1'b1; d.alu_op = ALUOP_W'(2'b01); end
            11'b000101?????: d.kind = K_BR;
            11'b11111111111: d.kind = K_HALT;
            default:         d.kind = K_ILL;
        endcase
        return d;
    endfunction

    // Strobes a state presents for its whole stay; computed while entering it.
    function automatic outs_t outs_for(input state_t s, input bundle_t b, input logic skip);
        outs_t o;
        o = '0;
        case (s)
            S_FETCH:  o.inst_ready = 1'b1;
            S_DECODE: o.pc_write = skip;
            S_EXEC, S_MEM, S_WB: begin
                o.reg2loc        = b.reg2loc;
                o.alu_src        = b.alu_src;
                o.alu_op         = b.alu_op;
                o.mem_to_reg     = b.mem_to_reg;
                o.branch         = (s == S_EXEC) && (b.kind == K_BR);
                o.branch_zero    = (s == S_EXEC) && (b.kind == K_CBZ);
                o.branch_nonzero = (s == S_EXEC) && (b.kind == K_CBNZ);
                o.mem_read       = (s == S_MEM) && (b.kind == K_LDUR);
                o.mem_write      = (s == S_MEM) && (b.kind == K_STUR);
                o.reg_write      = (s == S_WB);
                o.pc_write       = (s == S_WB) ||
                                   ((s == S_EXEC) && ((b.kind == K_BR) || (b.kind == K_CBZ) ||
                                                      (b.kind == K_CBNZ)));
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    state_t           state_r;
    logic [10:0]      ir_r;
    bundle_t          dec_r;
    outs_t            out_r;
    logic             halted_r;
    logic             bus_err_r;
    logic             illegal_op_r;
    logic [CNT_W-1:0] cnt_r;

    bundle_t dec_now_s;
    bundle_t dec_fetch_s;
    logic    fetch_skip_s;
    logic    timeout_s;

    assign dec_now_s    = decode_op(ir_r);
    assign dec_fetch_s  = decode_op(inst31_21);
    assign fetch_skip_s = (dec_fetch_s.kind == K_ILL) && (ILLEGAL_TRAP == 0);
    assign timeout_s    = (MEM_TIMEOUT > 0) && (cnt_r == CNT_LAST);

    // Sequencing, IR/bundle capture, MEM wait counter and sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_FETCH;
            ir_r         <= 11'd0;
            dec_r        <= '0;
            out_r        <= outs_for(S_FETCH, '0, 1'b0);
            halted_r     <= 1'b0;
            bus_err_r    <= 1'b0;
            illegal_op_r <= 1'b0;
            cnt_r        <= '0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (inst_valid) begin
                        state_r      <= S_DECODE;
                        ir_r         <= inst31_21;
                        illegal_op_r <= fetch_skip_s;
                        out_r        <= outs_for(S_DECODE, dec_fetch_s, fetch_skip_s);
                    end
                end
                S_DECODE: begin
                    dec_r <= dec_now_s;
                    case (dec_now_s.kind)
                        K_HALT: begin
                            state_r  <= S_HALTED;
                            halted_r <= 1'b1;
                            out_r    <= outs_for(S_HALTED, dec_now_s, 1'b0);
                        end
                        K_ILL: begin
                            if (ILLEGAL_TRAP != 0) begin
                                state_r      <= S_ERROR;
                                illegal_op_r <= 1'b1;
                                out_r        <= outs_for(S_ERROR, dec_now_s, 1'b0);
                            end else begin
                                state_r      <= S_FETCH;
                                illegal_op_r <= 1'b0;
                                out_r        <= outs_for(S_FETCH, dec_now_s, 1'b0);
                            end
                        end
                        default: begin
                            state_r <= S_EXEC;
                            out_r   <= outs_for(S_EXEC, dec_now_s, 1'b0);
                        end
                    endcase
                end
                S_EXEC: begin
                    case (dec_r.kind)
                        K_BR, K_CBZ, K_CBNZ: begin
                            state_r <= S_FETCH;
                            out_r   <= outs_for(S_FETCH, dec_r, 1'b0);
                        end
                        K_LDUR, K_STUR: begin
                            state_r <= S_MEM;
                            cnt_r   <= '0;
                            out_r   <= outs_for(S_MEM, dec_r, 1'b0);
                        end
                        default: begin
                            state_r <= S_WB;
                            out_r   <= outs_for(S_WB, dec_r, 1'b0);
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (dec_r.kind == K_LDUR) begin
                            state_r <= S_WB;
                            out_r   <= outs_for(S_WB, dec_r, 1'b0);
                        end else begin
                            state_r <= S_FETCH;
                            out_r   <= outs_for(S_FETCH, dec_r, 1'b0);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (timeout_s) begin
                            state_r   <= S_ERROR;
                            bus_err_r <= 1'b1;
                            out_r     <= outs_for(S_ERROR, dec_r, 1'b0);
                        end
                    end
                end
                S_WB: begin
                    state_r <= S_FETCH;
                    out_r   <= outs_for(S_FETCH, dec_r, 1'b0);
                end
                default: state_r <= state_r;
            endcase
        end
    end

    // ir_write and the store-completion pc_write follow their handshake input in-cycle
    assign inst_ready     = out_r.inst_ready;
    assign ir_write       = out_r.inst_ready & inst_valid;
    assign pc_write       = out_r.pc_write |
                            ((state_r == S_MEM) & (dec_r.kind == K_STUR) & mem_ack);
    assign reg2loc        = out_r.reg2loc;
    assign alu_src        = out_r.alu_src;
    assign alu_op         = out_r.alu_op;
    assign branch         = out_r.branch;
    assign branch_zero    = out_r.branch_zero;
    assign branch_nonzero = out_r.branch_nonzero;
    assign mem_read       = out_r.mem_read;
    assign mem_write      = out_r.mem_write;
    assign mem_to_reg     = out_r.mem_to_reg;
    assign reg_write      = out_r.reg_write;
    assign halted         = halted_r;
    assign illegal_op     = illegal_op_r;
    assign bus_err        = bus_err_r;
    assign state          = state_r;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized bench for cpu_control_fsm: a per-instruction cycle schedule model
// built from the latency/strobe rules, checked every cycle on two parameterisations.
module tb_cpu_control_fsm;
    localparam int C_LD = 0, C_ST = 1, C_ALU = 2, C_ADDI = 3, C_CBZ = 4, C_CBNZ = 5;
    localparam int C_B = 6, C_ILL = 7, C_HALT = 8;

    typedef struct packed {
        logic [2:0] st;
        logic       rdy, irw, pcw, r2l;
        logic [1:0] asrc, aop;
        logic       br, bz, bnz, mrd, mwr, m2r, rw, hlt, ill, berr;
    } outs_t;

    logic        clk;
    logic [1:0]  rstn;
    logic [10:0] inst31_21;
    logic        inst_valid, mem_ack;
    logic [1:0]  rdy, irw, pcw, r2l, br, bz, bnz, mrd, mwr, m2r, rw, hlt, ill, berr;
    logic [1:0]  asrc [2];
    logic [1:0]  aop [2];
    logic [2:0]  st [2];
    int          sel;
    int          n_checks = 0;
    int          n_pass = 0;

    cpu_control_fsm #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(1), .ALUOP_W(2)) dut_a (
        .clk(clk), .rst_n(rstn[0]), .inst31_21(inst31_21), .inst_valid(inst_valid),
        .inst_ready(rdy[0]), .mem_ack(mem_ack), .ir_write(irw[0]), .pc_write(pcw[0]),
        .reg2loc(r2l[0]), .alu_src(asrc[0]), .alu_op(aop[0]), .branch(br[0]),
        .branch_zero(bz[0]), .branch_nonzero(bnz[0]), .mem_read(mrd[0]), .mem_write(mwr[0]),
        .mem_to_reg(m2r[0]), .reg_write(rw[0]), .halted(hlt[0]), .illegal_op(ill[0]),
        .bus_err(berr[0]), .state(st[0]));

    cpu_control_fsm #(.MEM_TIMEOUT(16), .ILLEGAL_TRAP(0), .ALUOP_W(2)) dut_b (
        .clk(clk), .rst_n(rstn[1]), .inst31_21(inst31_21), .inst_valid(inst_valid),
        .inst_ready(rdy[1]), .mem_ack(mem_ack), .ir_write(irw[1]), .pc_write(pcw[1]),
        .reg2loc(r2l[1]), .alu_src(asrc[1]), .alu_op(aop[1]), .branch(br[1]),
        .branch_zero(bz[1]), .branch_nonzero(bnz[1]), .mem_read(mrd[1]), .mem_write(mwr[1]),
        .mem_to_reg(m2r[1]), .reg_write(rw[1]), .halted(hlt[1]), .illegal_op(ill[1]),
        .bus_err(berr[1]), .state(st[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t observed(input int s);
        return {st[s], rdy[s], irw[s], pcw[s], r2l[s], asrc[s], aop[s], br[s], bz[s], bnz[s],
                mrd[s], mwr[s], m2r[s], rw[s], hlt[s], ill[s], berr[s]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int classify(input logic [10:0] op);
        casez (op)
            11'b11111000010: return C_LD;
            11'b11111000000: return C_ST;
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: return C_ALU;
            11'b1001000100?: return C_ADDI;
            11'b10110100???: return C_CBZ;
            11'b10110101???: return C_CBNZ;
            11'b000101?????: return C_B;
            11'b11111111111: return C_HALT;
            default:         return C_ILL;
        endcase
    endfunction

    function automatic logic [10:0] gen_op(input int cls);
        logic [31:0] r;
        logic [10:0] op;
        r = $urandom;
        case (cls)
            C_LD:   op = 11'b11111000010;
            C_ST:   op = 11'b11111000000;
            C_ALU:  op = (r[5:4] == 2'd0) ? 11'b10001011000 : (r[5:4] == 2'd1) ? 11'b11001011000 :
                         (r[5:4] == 2'd2) ? 11'b10001010000 : 11'b10101010000;
            C_ADDI: op = {10'b1001000100, r[0]};
            C_CBZ:  op = {8'b10110100, r[2:0]};
            C_CBNZ: op = {8'b10110101, r[2:0]};
            C_B:    op = {6'b000101, r[4:0]};
            C_HALT: op = 11'b11111111111;
            default: begin
                op = 11'd0;
                for (int t = 0; t < 16; t++) begin
                    r = $urandom;
                    if (classify(r[10:0]) == C_ILL) begin
                        op = r[10:0];
                        break;
                    end
                end
            end
        endcase
        return op;
    endfunction

    // reg2loc / alu_src / alu_op / mem_to_reg from the opcode-class table
    function automatic outs_t fields(input int cls);
        outs_t f;
        f = '0;
        case (cls)
            C_LD:          begin f.asrc = 2'b01; f.m2r = 1'b1; end
            C_ST:          begin f.r2l = 1'b1; f.asrc = 2'b01; end
            C_ALU:         f.aop = 2'b10;
            C_ADDI:        begin f.asrc = 2'b10; f.aop = 2'b10; end
            C_CBZ, C_CBNZ: begin f.r2l = 1'b1; f.aop = 2'b01; end
            default:       f = '0;
        endcase
        return f;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        sel = s;
        rstn = 2'b00;
        inst_valid = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn[s] = 1'b1;
        check_val("reset", 32'(observed(sel)), 32'({3'd0, 1'b1, 17'd0}));
        next_cycle();
    endtask

    // One instruction: idle FETCH cycles, then the expected per-cycle schedule.
    task automatic run_instr(input logic [10:0] op, input int n_ack, input int idle, input int abort_at);
        int cls, tmo, m, mi, term, s;
        logic trap, acked;
        outs_t e, f;
        int q[$];
        logic [31:0] r;
        cls = classify(op);
        trap = (sel == 0);
        tmo = (sel == 0) ? 4 : 16;
        f = fields(cls);
        acked = (n_ack > 0) && (n_ack <= tmo);
        m = acked ? n_ack : tmo;
        term = -1;
        q = '{0, 1};
        case (cls)
            C_HALT: term = 5;
            C_ILL:  term = trap ? 6 : -1;
            C_LD, C_ST: begin
                q.push_back(2);
                repeat (m) q.push_back(3);
                if (!acked) term = 6;
                else if (cls == C_LD) q.push_back(4);
            end
            C_ALU, C_ADDI: begin q.push_back(2); q.push_back(4); end
            default: q.push_back(2);
        endcase
        for (int k = 0; k < idle; k++) begin
            r = $urandom;
            inst_valid = 1'b0;
            inst31_21 = r[10:0];
            mem_ack = r[11];
            e = '0; e.st = 3'd0; e.rdy = 1'b1;
            @(negedge clk);
            check_val("idle", 32'(observed(sel)), 32'(e));
            next_cycle();
        end
        mi = 0;
        for (int i = 0; i < q.size(); i++) begin
            s = q[i];
            r = $urandom;
            inst_valid = (i == 0) ? 1'b1 : r[12];
            inst31_21 = (i == 0) ? op : r[10:0];
            if (s == 3) begin
                mi++;
                mem_ack = acked && (mi == n_ack);
            end else begin
                mem_ack = r[11];
            end
            e = f;
            if (s < 2) begin e.r2l = 1'b0; e.asrc = 2'b00; e.aop = 2'b00; e.m2r = 1'b0; end
            e.st   = 3'(s);
            e.rdy  = (s == 0);
            e.irw  = (s == 0);
            e.pcw  = (i == q.size() - 1) && (term < 0);
            e.br   = (s == 2) && (cls == C_B);
            e.bz   = (s == 2) && (cls == C_CBZ);
            e.bnz  = (s == 2) && (cls == C_CBNZ);
            e.mrd  = (s == 3) && (cls == C_LD);
            e.mwr  = (s == 3) && (cls == C_ST);
            e.rw   = (s == 4);
            e.hlt  = 1'b0;
            e.ill  = (s == 1) && (cls == C_ILL) && !trap;
            e.berr = 1'b0;
            @(negedge clk);
            check_val($sformatf("op%03h_c%0d", op, i), 32'(observed(sel)), 32'(e));
            if (i == abort_at) begin
                #2;
                inst_valid = 1'b0;
                mem_ack = 1'b0;
                rstn[sel] = 1'b0;
                #1;
                check_val("abort", 32'(observed(sel)), 32'({3'd0, 1'b1, 17'd0}));
                return;
            end
            next_cycle();
        end
        if (term >= 0) begin
            for (int k = 0; k < 3; k++) begin
                r = $urandom;
                inst_valid = r[0];
                mem_ack = r[1];
                inst31_21 = r[12:2];
                e = '0;
                e.st = 3'(term);
                e.hlt = (term == 5);
                e.ill = (cls == C_ILL);
                e.berr = (term == 6) && (cls != C_ILL);
                @(negedge clk);
                check_val($sformatf("term%0d_c%0d", term, k), 32'(observed(sel)), 32'(e));
                next_cycle();
            end
        end
    endtask

    initial begin
        sel = 0;
        rstn = 2'b00;
        inst_valid = 1'b0;
        mem_ack = 1'b0;
        inst31_21 = 11'd0;
        do_reset(0);
        run_instr(11'b10001011000, 0, 0, -1);
        run_instr(11'b11111000010, 3, 1, -1);
        run_instr(11'b10110100101, 0, 2, -1);
        run_instr(11'b10010001001, 0, 0, -1);
        run_instr(11'b11111000000, 4, 0, -1);
        run_instr(11'b11111000010, 1, 0, -1);
        for (int n = 0; n < 40; n++) begin
            run_instr(gen_op($urandom_range(0, 6)), $urandom_range(1, 4), $urandom_range(0, 2), -1);
        end
        run_instr(11'b11111000000, 0, 0, -1);
        do_reset(0);
        run_instr(11'b00000000000, 0, 0, -1);
        do_reset(0);
        run_instr(11'b11111111111, 0, 1, -1);
        do_reset(0);
        run_instr(11'b11111000010, 3, 0, 4);
        do_reset(0);
        run_instr(11'b10101010000, 0, 0, -1);
        do_reset(1);
        run_instr(11'b00000000000, 0, 0, -1);
        for (int n = 0; n < 30; n++) begin
            run_instr(gen_op($urandom_range(0, 7)), $urandom_range(1, 6), $urandom_range(0, 2), -1);
        end
        run_instr(11'b11111111111, 0, 0, -1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
